// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 rotate/shift datapath: mode encodings,
// the standard sigma/Sigma amounts and barrel-level distribution helpers.
package sha_pkg;

  typedef enum logic [1:0] {
    MODE_ROTR = 2'b00,
    MODE_ROTL = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_e;

  localparam int unsigned SHA_AMT_NUM = 10;
  localparam int unsigned SHA_AMTS [SHA_AMT_NUM] = '{2, 6, 7, 11, 13, 17, 18, 19, 22, 25};

  function automatic int unsigned lvl_per_stage(input int unsigned log2w, input int unsigned pipe);
    return (log2w + pipe - 1) / pipe;
  endfunction

  // Earliest stages take a full share of levels; trailing stages may get fewer or none.
  function automatic int unsigned lvl_count(input int unsigned log2w, input int unsigned per,
                                            input int unsigned stage);
    int unsigned first;
    first = stage * per;
    if (first >= log2w) return 0;
    return (log2w - first < per) ? (log2w - first) : per;
  endfunction

endpackage

// File: rtl/rotator_stage.sv
// One pipeline stage: LVL_N barrel rotate levels starting at LVL_FIRST,
// optional shift masking (last stage only), output register and handshake.
module rotator_stage
  import sha_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned LVL_FIRST = 0,
  parameter int unsigned LVL_N     = 1,
  parameter bit          LAST      = 1'b0,
  localparam int unsigned AW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_ramt,
  input  logic [AW-1:0]    in_amt,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_ramt,
  output logic [AW-1:0]    out_amt,
  output logic [1:0]       out_mode,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] lvl [0:LVL_N];
  logic [WIDTH-1:0] res;

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [AW-1:0]    ramt_q,  ramt_d;
  logic [AW-1:0]    amt_q,   amt_d;
  logic [1:0]       mode_q,  mode_d;
  logic [TAG_W-1:0] tag_q,   tag_d;

  assign lvl[0] = in_data;

  for (genvar g = 0; g < LVL_N; g++) begin : g_lvl
    localparam int unsigned S = 2 ** (LVL_FIRST + g);
    assign lvl[g+1] = in_ramt[LVL_FIRST+g] ? {lvl[g][S-1:0], lvl[g][WIDTH-1:S]} : lvl[g];
  end

  always_comb begin
    res      = lvl[LVL_N];
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    ramt_d   = ramt_q;
    amt_d    = amt_q;
    mode_d   = mode_q;
    tag_d    = tag_q;
    // Shifts are a full rotate followed by clearing the bits that wrapped around.
    if (LAST) begin
      unique case (mode_e'(in_mode))
        MODE_SHR: res = lvl[LVL_N] & (ONES >> in_amt);
        MODE_SHL: res = lvl[LVL_N] & (ONES << in_amt);
        default:  res = lvl[LVL_N];
      endcase
    end
    if (in_ready) valid_d = in_valid;
    if (in_valid && in_ready) begin
      data_d = res;
      ramt_d = in_ramt;
      amt_d  = in_amt;
      mode_d = in_mode;
      tag_d  = in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ramt_q  <= '0;
      amt_q   <= '0;
      mode_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ramt_q  <= ramt_d;
      amt_q   <= amt_d;
      mode_q  <= mode_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ramt  = ramt_q;
  assign out_amt   = amt_q;
  assign out_mode  = mode_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/rotator_pipe.sv
// Pipelined barrel rotate/shift unit (ROTR/ROTL/SHR/SHL) with valid/ready
// handshake and sideband tag, built from PIPE rotator_stage instances.
module rotator_pipe
  import sha_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PIPE  = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [1:0]               in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     busy
);

  localparam int unsigned AW  = $clog2(WIDTH);
  localparam int unsigned PER = lvl_per_stage(AW, PIPE);

  logic             v    [0:PIPE];
  logic             rdy  [0:PIPE];
  logic [WIDTH-1:0] data [0:PIPE];
  logic [AW-1:0]    ramt [0:PIPE];
  logic [AW-1:0]    amt  [0:PIPE];
  logic [1:0]       mode [0:PIPE];
  logic [TAG_W-1:0] tag  [0:PIPE];
  logic             left;
  logic             unused_ctl;

  // Left operations become right rotates by (WIDTH-k) mod WIDTH.
  assign left    = (mode_e'(in_mode) == MODE_ROTL) || (mode_e'(in_mode) == MODE_SHL);
  assign v[0]    = in_valid;
  assign data[0] = in_data;
  assign ramt[0] = left ? -in_amt : in_amt;
  assign amt[0]  = in_amt;
  assign mode[0] = in_mode;
  assign tag[0]  = in_tag;
  assign in_ready = rdy[0];
  assign rdy[PIPE] = out_ready;

  for (genvar i = 0; i < PIPE; i++) begin : g_stage
    rotator_stage #(
      .WIDTH    (WIDTH),
      .TAG_W    (TAG_W),
      .LVL_FIRST(i * PER),
      .LVL_N    (lvl_count(AW, PER, i)),
      .LAST     (i == PIPE - 1)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (v[i]),
      .in_ready (rdy[i]),
      .in_data  (data[i]),
      .in_ramt  (ramt[i]),
      .in_amt   (amt[i]),
      .in_mode  (mode[i]),
      .in_tag   (tag[i]),
      .out_valid(v[i+1]),
      .out_ready(rdy[i+1]),
      .out_data (data[i+1]),
      .out_ramt (ramt[i+1]),
      .out_amt  (amt[i+1]),
      .out_mode (mode[i+1]),
      .out_tag  (tag[i+1])
    );
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 1; i <= PIPE; i++) busy = busy | v[i];
  end

  assign out_valid  = v[PIPE];
  assign out_data   = data[PIPE];
  assign out_tag    = tag[PIPE];
  assign unused_ctl = ^{ramt[PIPE], amt[PIPE], mode[PIPE]};

endmodule
